// File: rtl/i2s_cdc_arb_pkg.sv
// Shared constants for the I2S CDC arbiter: holding-state encodings,
// default tag width and the tag-width sanity rule.
package i2s_cdc_arb_pkg;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam int unsigned DEFAULT_TAG_W = 1;

  // Tag must be wide enough to name every requester.
  function automatic bit tag_w_ok(input int unsigned n_req, input int unsigned tag_w);
    return (64'(1) << tag_w) >= 64'(n_req);
  endfunction

endpackage

// File: rtl/i2s_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping modulo N.
module i2s_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  int unsigned pos;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr is always below N, so one subtraction completes the wrap
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/i2s_cdc_arb.sv
// Round-robin arbiter with a 1-entry tagged holding register feeding one
// async CDC source channel shared by N_REQ requesters.
module i2s_cdc_arb
  import i2s_cdc_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_REQ = 2,
  parameter int unsigned TAG_W = DEFAULT_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ack,
  output logic [WIDTH+TAG_W-1:0] cdc_data,
  output logic                   cdc_valid,
  input  logic                   cdc_ack,
  output logic                   busy,
  output logic [TAG_W-1:0]       last_grant
);

  localparam int unsigned DW = WIDTH + TAG_W;

  if (!tag_w_ok(N_REQ, TAG_W)) begin : g_bad_tag_w
    $error("i2s_cdc_arb: TAG_W too narrow for N_REQ");
  end

  logic [0:0]       state_q, state_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] last_q, last_d;
  logic [DW-1:0]    data_q, data_d;

  logic             pick_any;
  logic [N_REQ-1:0] pick_grant;
  logic [TAG_W-1:0] pick_idx;
  logic [WIDTH-1:0] pick_payload;
  logic             take_c;

  i2s_rr_pick #(
    .N     (N_REQ),
    .IDX_W (TAG_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .any   (pick_any),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign pick_payload = req_data[32'(pick_idx)*WIDTH +: WIDTH];

  // Holding state, pointer and tagged word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // A take can reuse the register in the same cycle the CDC source drains it
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    data_d  = data_q;
    take_c  = enable && pick_any && ((state_q == EMPTY) || cdc_ack);
    req_ack = take_c ? pick_grant : '0;
    case (state_q)
      EMPTY: begin
        if (take_c) state_d = FULL;
      end
      default: begin
        if (cdc_ack && !take_c) state_d = EMPTY;
      end
    endcase
    if (take_c) begin
      data_d = {pick_idx, pick_payload};
      last_d = pick_idx;
      ptr_d  = (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + TAG_W'(1);
    end
  end

  assign cdc_valid  = (state_q == FULL);
  assign busy       = (state_q == FULL);
  assign cdc_data   = data_q;
  assign last_grant = last_q;

endmodule

// File: tb/tb_i2s_cdc_arb.sv
// Self-checking bench for i2s_cdc_arb: 2-requester instance against a
// behavioural model plus a 3-requester instance for tag/pointer wrap.
module tb_i2s_cdc_arb;

  logic        clk;
  logic        rst_n;

  logic        enable;
  logic [63:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_ack;
  logic [32:0] cdc_data;
  logic        cdc_valid;
  logic        cdc_ack;
  logic        busy;
  logic [0:0]  last_grant;

  logic        enable3;
  logic [95:0] req_data3;
  logic [2:0]  req_valid3;
  logic [2:0]  req_ack3;
  logic [33:0] cdc_data3;
  logic        cdc_valid3;
  logic        cdc_ack3;
  logic        busy3;
  logic [1:0]  last_grant3;

  int checks;
  int errors;

  // Model of the 2-requester instance
  bit          m_full;
  logic [32:0] m_data;
  int          m_ptr;
  int          m_last;

  i2s_cdc_arb #(.WIDTH(32), .N_REQ(2), .TAG_W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ack    (req_ack),
    .cdc_data   (cdc_data),
    .cdc_valid  (cdc_valid),
    .cdc_ack    (cdc_ack),
    .busy       (busy),
    .last_grant (last_grant)
  );

  i2s_cdc_arb #(.WIDTH(32), .N_REQ(3), .TAG_W(2)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable3),
    .req_data   (req_data3),
    .req_valid  (req_valid3),
    .req_ack    (req_ack3),
    .cdc_data   (cdc_data3),
    .cdc_valid  (cdc_valid3),
    .cdc_ack    (cdc_ack3),
    .busy       (busy3),
    .last_grant (last_grant3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [1:0] v, input int p);
    for (int k = 0; k < 2; k++)
      if (v[(p + k) % 2]) return (p + k) % 2;
    return -1;
  endfunction

  function automatic logic [1:0] exp_ack();
    int w;
    logic [1:0] a;
    a = 2'b00;
    w = pick(req_valid, m_ptr);
    if (enable && w >= 0 && (!m_full || cdc_ack)) a[w] = 1'b1;
    return a;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_ptr  = 0;
    m_last = 0;
  endtask

  // One clock: model sees the same inputs the DUT samples at the edge
  task automatic advance();
    int w;
    @(posedge clk);
    w = pick(req_valid, m_ptr);
    if (enable && w >= 0 && (!m_full || cdc_ack)) begin
      m_full = 1'b1;
      m_data = {w[0], req_data[w*32 +: 32]};
      m_last = w;
      m_ptr  = (w + 1) % 2;
    end else if (m_full && cdc_ack) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; req_data = '0; req_valid = '0; cdc_ack = 1'b0;
    enable3 = 1'b1; req_data3 = '0; req_valid3 = '0; cdc_ack3 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL reset_req_ack got %b exp 00", req_ack); end
    checks++; if (cdc_valid !== 1'b0) begin errors++; $display("FAIL reset_cdc_valid got %b exp 0", cdc_valid); end
    checks++; if (cdc_data !== 33'h0) begin errors++; $display("FAIL reset_cdc_data got %h exp 0", cdc_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL reset_last_grant got %b exp 0", last_grant); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_data[31:0] = 32'hA5A5_0001;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL single_ack got %b exp 01", req_ack); end
    advance();
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (cdc_valid !== 1'b1 || cdc_data !== 33'h0_A5A5_0001 || busy !== 1'b1) begin
        errors++; $display("FAIL single_hold c%0d valid %b data %h busy %b exp 1 0a5a50001 1", i, cdc_valid, cdc_data, busy);
      end
      if (i < 2) advance();
    end
    cdc_ack = 1'b1;
    advance();
    cdc_ack = 1'b0;
    #1;
    checks++; if (cdc_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain valid %b busy %b exp 0 0", cdc_valid, busy); end
    checks++; if (cdc_data !== 33'h0_A5A5_0001) begin errors++; $display("FAIL single_data_hold got %h exp 0a5a50001", cdc_data); end
  endtask

  task automatic test_contention();
    int exp_tag;
    req_valid = 2'b11;
    exp_tag = m_ptr;
    for (int i = 0; i < 8; i++) begin
      req_data = {$urandom, $urandom};
      cdc_ack = m_full;
      #1;
      checks++; if (req_ack !== exp_ack()) begin errors++; $display("FAIL contention_ack c%0d got %b exp %b", i, req_ack, exp_ack()); end
      checks++; if (req_ack == 2'b11) begin errors++; $display("FAIL contention_onehot c%0d got %b exp one-hot", i, req_ack); end
      advance();
      #1;
      checks++;
      if (cdc_data !== m_data || 32'(last_grant) !== exp_tag || 32'(cdc_data[32]) !== exp_tag) begin
        errors++; $display("FAIL contention_word c%0d data %h last %0d exp %h %0d", i, cdc_data, last_grant, m_data, exp_tag);
      end
      exp_tag = 1 - exp_tag;
    end
    cdc_ack = 1'b0;
    req_valid = 2'b00;
    cdc_ack = 1'b1;
    advance();
    cdc_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Fill with requester 0, then ack while requester 1 waits
    while (m_ptr != 0) begin
      req_valid = 2'b10; advance(); req_valid = 2'b00; cdc_ack = 1'b1; advance(); cdc_ack = 1'b0;
    end
    req_valid = 2'b01; req_data = {32'hBEEF_0002, 32'h1234_5678};
    advance();
    req_valid = 2'b10; cdc_ack = 1'b1;
    #1;
    checks++; if (req_ack !== 2'b10) begin errors++; $display("FAIL b2b_ack got %b exp 10", req_ack); end
    advance();
    req_valid = 2'b00; cdc_ack = 1'b0;
    #1;
    checks++; if (cdc_valid !== 1'b1 || cdc_data !== 33'h1_BEEF_0002) begin errors++; $display("FAIL b2b_word valid %b data %h exp 1 1beef0002", cdc_valid, cdc_data); end
    cdc_ack = 1'b1; advance(); cdc_ack = 1'b0;
  endtask

  task automatic test_enable();
    req_valid = 2'b01; advance();
    req_valid = 2'b11; enable = 1'b0; cdc_ack = 1'b1;
    #1;
    checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL enable_noack_full got %b exp 00", req_ack); end
    advance();
    cdc_ack = 1'b0;
    #1;
    checks++; if (cdc_valid !== 1'b0 || req_ack !== 2'b00) begin errors++; $display("FAIL enable_drain valid %b ack %b exp 0 00", cdc_valid, req_ack); end
    advance();
    enable = 1'b1;
    #1;
    checks++; if (req_ack !== 2'b10) begin errors++; $display("FAIL enable_resume_ack got %b exp 10", req_ack); end
    advance();
    req_valid = 2'b00; cdc_ack = 1'b1; advance(); cdc_ack = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_valid = 2'($urandom);
      req_data  = {$urandom, $urandom};
      enable    = ($urandom_range(0, 9) < 8);
      cdc_ack   = m_full ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      #1;
      checks++; if (req_ack !== exp_ack()) begin errors++; $display("FAIL random_ack c%0d got %b exp %b", i, req_ack, exp_ack()); end
      advance();
      #1;
      checks++;
      if (cdc_valid !== m_full || busy !== m_full || cdc_data !== m_data || 32'(last_grant) !== m_last) begin
        errors++; $display("FAIL random_state c%0d valid %b data %h last %0d exp %b %h %0d", i, cdc_valid, cdc_data, last_grant, m_full, m_data, m_last);
      end
    end
    enable = 1'b1; req_valid = 2'b00; cdc_ack = 1'b1; advance(); cdc_ack = 1'b0;
  endtask

  task automatic test_wrap3();
    req_data3 = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    req_valid3 = 3'b100;
    #1;
    checks++; if (req_ack3 !== 3'b100) begin errors++; $display("FAIL wrap_ack2 got %b exp 100", req_ack3); end
    advance();
    req_valid3 = 3'b001; cdc_ack3 = 1'b1;
    #1;
    checks++; if (cdc_data3[33:32] !== 2'b10 || cdc_data3[31:0] !== 32'h3333_0002) begin errors++; $display("FAIL wrap_tag2 got %h exp 2_33330002", cdc_data3); end
    checks++; if (req_ack3 !== 3'b001) begin errors++; $display("FAIL wrap_ack0 got %b exp 001", req_ack3); end
    advance();
    req_valid3 = 3'b011;
    #1;
    checks++; if (cdc_data3[33:32] !== 2'b00 || last_grant3 !== 2'b00) begin errors++; $display("FAIL wrap_tag0 data %h last %b exp tag 00", cdc_data3, last_grant3); end
    checks++; if (req_ack3 !== 3'b010) begin errors++; $display("FAIL wrap_ptr1 got %b exp 010", req_ack3); end
    advance();
    req_valid3 = 3'b000; cdc_ack3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10; advance(); req_valid = 2'b00;
    #1;
    checks++; if (cdc_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre valid got %b exp 1", cdc_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cdc_valid !== 1'b0 || cdc_data !== 33'h0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async valid %b data %h busy %b exp 0 0 0", cdc_valid, cdc_data, busy); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL midrst_first_grant got %b exp 01", req_ack); end
    advance();
    req_valid = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_enable();
    test_random();
    test_wrap3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
